// File: rtl/f1_pkg.sv
// f1_pkg: shared state encoding and lamp-count default for the start-light sequencer
package f1_pkg;
  typedef enum logic [1:0] {IDLE, FILL, HOLD} f1_state_t;
  localparam int F1_LIGHTS_DEFAULT = 8;
endpackage

// File: rtl/f1_step_timer.sv
// f1_step_timer: counts en ticks and flags the last tick of each lamp step
module f1_step_timer #(
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [STEP_W-1:0] step_len,
  output logic              step_done
);
  logic [STEP_W-1:0] r_step_cnt;
  assign step_done = en && (r_step_cnt == step_len - STEP_W'(1));
  // step counter: restarts on every completed step, frozen while en is low
  always_ff @(posedge clk) begin
    if (rst || clr) r_step_cnt <= '0;
    else if (step_done) r_step_cnt <= '0;
    else if (en) r_step_cnt <= r_step_cnt + STEP_W'(1);
  end
endmodule

// File: rtl/f1_light_seq.sv
// f1_light_seq: fills an N-lamp bar one lamp per step, holds, then strobes lights_out
module f1_light_seq
  import f1_pkg::*;
#(
  parameter int N_LIGHTS = F1_LIGHTS_DEFAULT,
  parameter int STEP_W   = 16,
  parameter int DELAY_W  = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                trigger,
  input  logic                abort,
  input  logic                mode,
  input  logic [STEP_W-1:0]   step_ticks,
  input  logic [DELAY_W-1:0]  delay_ticks,
  output logic [N_LIGHTS-1:0] data_out,
  output logic                busy,
  output logic                lights_out
);
  localparam int LIT_W = $clog2(N_LIGHTS + 1);
  f1_state_t           r_state;
  logic [N_LIGHTS-1:0] r_data;
  logic                r_busy;
  logic                r_lights_out;
  logic [LIT_W-1:0]    r_lit;
  logic [DELAY_W-1:0]  r_dly_cnt;
  logic [STEP_W-1:0]   r_step_len;
  logic                w_fill;
  logic                w_step_done;
  assign w_fill     = (r_state == FILL);
  assign data_out   = r_data;
  assign busy       = r_busy;
  assign lights_out = r_lights_out;
  f1_step_timer #(.STEP_W(STEP_W)) u_step_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (abort || !w_fill),
    .en        (en && w_fill),
    .step_len  (r_step_len),
    .step_done (w_step_done)
  );
  // sequencer: abort behaves like reset but only for this block's state
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      r_state      <= IDLE;
      r_data       <= '0;
      r_busy       <= 1'b0;
      r_lights_out <= 1'b0;
      r_lit        <= '0;
      r_dly_cnt    <= '0;
      r_step_len   <= STEP_W'(1);
    end else begin
      r_lights_out <= 1'b0;
      case (r_state)
        IDLE: begin
          r_data <= '0;
          if (trigger || mode) begin
            r_state    <= FILL;
            r_busy     <= 1'b1;
            r_lit      <= '0;
            r_step_len <= (step_ticks == '0) ? STEP_W'(1) : step_ticks;
          end
        end
        FILL: begin
          if (w_step_done) begin
            r_data <= {r_data[N_LIGHTS-2:0], 1'b1};
            r_lit  <= r_lit + LIT_W'(1);
            if (r_lit == LIT_W'(N_LIGHTS - 1)) begin
              r_state   <= HOLD;
              r_dly_cnt <= delay_ticks;
            end
          end
        end
        HOLD: begin
          if (en) begin
            if (r_dly_cnt == '0) begin
              r_data       <= '0;
              r_busy       <= 1'b0;
              r_lights_out <= 1'b1;
              r_state      <= IDLE;
            end else r_dly_cnt <= r_dly_cnt - DELAY_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_data  <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
